// File: rtl/gin_tag_gen.sv
`default_nettype none
// ============================================================================
// Module   : gin_tag_gen
// Purpose  : Upstream feeder for the GIN bus. Attaches a scheduled ID tag to
//            each raw data word and emits {tag, data} packets through a
//            2-entry output FIFO with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module gin_tag_gen #(
  parameter int ID_BITWIDTH     = 4,
  parameter int DATA_BITWIDTH   = 8,
  parameter int PACKET_BITWIDTH = ID_BITWIDTH + DATA_BITWIDTH,
  parameter int CNT_BITWIDTH    = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [ID_BITWIDTH-1:0]     i_cfg_tag_start,
  input  logic [ID_BITWIDTH-1:0]     i_cfg_tag_num,
  input  logic [CNT_BITWIDTH-1:0]    i_cfg_words_per_tag,
  input  logic                       i_cfg_valid,
  input  logic [DATA_BITWIDTH-1:0]   i_data,
  input  logic                       i_valid,
  output logic                       o_ready,
  output logic [PACKET_BITWIDTH-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_busy,
  output logic                       o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                     r_state;
  logic [ID_BITWIDTH-1:0]     r_tag_start;
  logic [ID_BITWIDTH-1:0]     r_tag_num;
  logic [CNT_BITWIDTH-1:0]    r_words_per_tag;
  logic [ID_BITWIDTH-1:0]     r_tag_idx;
  logic [CNT_BITWIDTH-1:0]    r_word_cnt;
  logic                       r_done;

  // FIFO storage: r_head is the entry presented on o_data, r_tail the second.
  logic [PACKET_BITWIDTH-1:0] r_head;
  logic [PACKET_BITWIDTH-1:0] r_tail;
  logic [1:0]                 r_count;

  logic                       w_push;
  logic                       w_pop;
  logic [ID_BITWIDTH-1:0]     w_tag;
  logic [PACKET_BITWIDTH-1:0] w_pkt;
  logic                       w_last_word;
  logic                       w_last_tag;
  logic                       w_drained;
  logic                       w_cfg_ok;

  // Ready depends only on state and registered occupancy, never on i_ready.
  assign o_ready = (r_state == ST_RUN) && (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign o_busy  = (r_state != ST_IDLE);
  assign o_done  = r_done;

  assign w_push = i_valid && o_ready;
  assign w_pop  = o_valid && i_ready;

  // Tag arithmetic wraps naturally at the tag width.
  assign w_tag  = r_tag_start + r_tag_idx;
  assign w_pkt  = {w_tag, i_data};

  assign w_last_word = (r_word_cnt == (r_words_per_tag - CNT_BITWIDTH'(1)));
  assign w_last_tag  = (r_tag_idx == (r_tag_num - ID_BITWIDTH'(1)));
  assign w_cfg_ok    = i_cfg_valid && (i_cfg_tag_num != '0) && (i_cfg_words_per_tag != '0);

  // The FIFO is empty after this edge when its final entry is popped now.
  assign w_drained = (r_count == 2'd0) || ((r_count == 2'd1) && w_pop);

  // Two-entry FIFO; head keeps its last value while the FIFO is empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= w_pkt;
          end else begin
            r_tail <= w_pkt;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_head <= r_tail;
          end
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Only reachable at one entry: the new word replaces the popped head.
          r_head <= w_pkt;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  // Schedule FSM: config latch, tag/word counting, drain and done pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_tag_start     <= '0;
      r_tag_num       <= '0;
      r_words_per_tag <= '0;
      r_tag_idx       <= '0;
      r_word_cnt      <= '0;
      r_done          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cfg_ok) begin
            r_tag_start     <= i_cfg_tag_start;
            r_tag_num       <= i_cfg_tag_num;
            r_words_per_tag <= i_cfg_words_per_tag;
            r_tag_idx       <= '0;
            r_word_cnt      <= '0;
            r_state         <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_push) begin
            if (w_last_word) begin
              r_word_cnt <= '0;
              if (w_last_tag) begin
                r_state <= ST_DRAIN;
              end else begin
                r_tag_idx <= r_tag_idx + ID_BITWIDTH'(1);
              end
            end else begin
              r_word_cnt <= r_word_cnt + CNT_BITWIDTH'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
